elevator_call_dispatcher: RTL and testbench
===========================================

Name: elevator_call_dispatcher

Overview:
- Drives the elevator floor FSM's control inputs: door-closed P and call code B0/B1.
- Latches floor-button calls for 3 floors and picks the next target floor in SCAN order (keep direction while calls remain ahead).
- Sequences door dwell, door close, move and arrival, and watches the FSM's current-floor output EA to detect arrival and faults.

Parameters:
- DOOR_OPEN_CYCLES, 8: cycles the door stays open after arrival, or after a same-floor call (1..255).
- CLOSE_SETTLE_CYCLES, 2: cycles with P=1 and the hold code before the move code is driven (1..255).
- MOVE_TIMEOUT, 16: maximum cycles in MOVE before a fault is declared (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- call  in  3  floor buttons, bit0=floor1, bit2=floor3; level or pulse, sampled every cycle
- ea  in  2  current floor from the floor FSM: 00=F1, 01=F2, 10=F3, 11=invalid
- door_obstruct  in  1  door obstruction sensor; used only when the optional feature is enabled
- p  out  1  door closed (1) / open (0), registered
- b0  out  1  call code MSB, registered
- b1  out  1  call code LSB, registered
- pending  out  3  latched outstanding calls
- busy  out  1  high in CLOSE or MOVE
- fault  out  1  sticky fault flag

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, p=0, {b0,b1}=00, pending=000, dir=up, counters=0, busy=0, fault=0.
- All outputs are registered and update on the clk edge after their cause.
- Floor index f: 0/1/2 for ea=00/01/10.
- Call code for target t, given current floor c: t=F1 gives 00; t=F2 gives 01; t=F3 gives 10 if c=F1, else 11.
- Hold code = code(t=c). With this rule the FSM never moves on the hold code.
- Call latch: pending |= call each cycle. A call bit equal to the current floor is not latched while in IDLE or OPEN.
  - In that case the state goes to (or stays in) OPEN and the dwell counter restarts.
- In CLOSE or MOVE, a call for the current floor is latched and served later.
- Target selection, evaluated when leaving IDLE or OPEN toward CLOSE:
  - nearest pending floor in dir;
  - if none, nearest pending floor opposite dir, and dir flips;
  - the target is latched and fixed until arrival or fault.
- IDLE: p=0, hold code. If pending != 0, go to CLOSE next cycle (target selected).
- OPEN: p=0, hold code, dwell counter counts DOOR_OPEN_CYCLES. At expiry, go to CLOSE if pending != 0, else IDLE.
- CLOSE: p=1, hold code for CLOSE_SETTLE_CYCLES, then MOVE.
- MOVE: p=1, code=code(target), timeout counter runs.
  - On the edge where ea==target: clear pending[target], go to OPEN (p=0 from that edge), dwell restarts.
  - If the timeout counter reaches MOVE_TIMEOUT first: go to FAULT.
- ea=11 observed in any state except FAULT: go to FAULT next edge.
- FAULT: fault=1 (sticky until rst), pending cleared, call inputs ignored, p=1, code=00.
  - On ea==00: go to OPEN (dwell runs) and resume normal operation; fault stays 1.
- A call and an arrival in the same cycle: both are applied. The arriving floor bit is cleared; other bits are set.
- rst mid-MOVE: immediate return to reset values. In-flight target and pending calls are discarded.
- busy=1 exactly in CLOSE and MOVE.

Optional Feature:
- Macro: DOOR_REOPEN_EN.
- Defined:
  - door_obstruct=1 in CLOSE aborts the close: next edge goes to OPEN, p=0, dwell restarts; the target is re-selected later.
  - door_obstruct=1 in OPEN holds the dwell counter at 0.
  - door_obstruct is ignored in MOVE.
- Undefined: door_obstruct is ignored entirely; CLOSE always completes.

Test Plan:
- Reset: assert rst 2 cycles -> p=0, {b0,b1}=00, pending=000, busy=0, fault=0 on the first edge.
- Single call: ea=00, pulse call=100 ->
  - pending=100;
  - CLOSE: p=1, code 00 for 2 cycles;
  - MOVE: code 10, busy=1;
  - FSM model sets ea=10 -> next edge p=0, pending=000, code 11;
  - IDLE after 8 cycles.
- SCAN order: ea=00, call=110 in one cycle ->
  - F2 served first (code 01);
  - after dwell, move to F3 with code 11;
  - pending ends 000, dir=up.
- Same-floor call: IDLE at F2 (ea=01), pulse call=010 -> pending stays 000, state OPEN, p stays 0, dwell restarts 8 cycles.
- Timeout/fault:
  - target F3, model holds ea=00 -> after 16 MOVE cycles fault=1, p=1, code 00, pending=000;
  - model ea=00 -> OPEN, p=0, fault stays 1 until rst.
- DOOR_REOPEN_EN defined: door_obstruct=1 during the CLOSE settle -> next edge p=0, OPEN, dwell restarts; close completes after obstruct drops and 8 cycles. Undefined build: obstruct ignored, MOVE entered on schedule.

Source files
------------

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher
// Latches floor calls for a 3-floor car, picks the next target in SCAN order
// and drives the floor FSM's door-closed (p) and call-code (b0,b1) inputs.
// The FSM's current floor (ea) closes the loop for arrival and fault detection.
// Optional feature macro: DOOR_REOPEN_EN (door obstruction reopens a closing
// door and holds the dwell timer while the door is obstructed).
module elevator_call_dispatcher #(
    parameter int DOOR_OPEN_CYCLES    = 8,
    parameter int CLOSE_SETTLE_CYCLES = 2,
    parameter int MOVE_TIMEOUT        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] call,
    input  logic [1:0] ea,
    input  logic       door_obstruct,
    output logic       p,
    output logic       b0,
    output logic       b1,
    output logic [2:0] pending,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_CLOSE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [7:0] DWELL_LAST  = 8'(DOOR_OPEN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(CLOSE_SETTLE_CYCLES - 1);
    localparam logic [7:0] MOVE_LAST   = 8'(MOVE_TIMEOUT - 1);

    // Code for target t seen from floor c; F3 from F2 uses 11 so the
    // hold code of every floor never makes the floor FSM move.
    function automatic logic [1:0] call_code(input logic [1:0] t, input logic [1:0] c);
        logic [1:0] r;
        case (t)
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b01;
            2'd2:    r = (c == 2'd0) ? 2'b10 : 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Nearest pending floor strictly ahead of c in the given direction;
    // returns {found, floor_index}.
    function automatic logic [2:0] scan_pick(input logic [2:0] pend, input logic [1:0] c,
                                             input logic up);
        logic [2:0] r;
        r = 3'b000;
        case (c)
            2'd0: begin
                if (up && pend[1])      r = 3'b1_01;
                else if (up && pend[2]) r = 3'b1_10;
                else                    r = 3'b000;
            end
            2'd1: begin
                if (up && pend[2])       r = 3'b1_10;
                else if (!up && pend[0]) r = 3'b1_00;
                else                     r = 3'b000;
            end
            2'd2: begin
                if (!up && pend[1])      r = 3'b1_01;
                else if (!up && pend[0]) r = 3'b1_00;
                else                     r = 3'b000;
            end
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    state_t     state_r;
    logic       p_r;
    logic [1:0] code_r;
    logic [2:0] pending_r;
    logic       dir_up_r;
    logic [1:0] target_r;
    logic [7:0] dwell_cnt_r;
    logic [7:0] settle_cnt_r;
    logic [7:0] move_cnt_r;
    logic       busy_r;
    logic       fault_r;

    logic       ea_valid_s;
    logic [2:0] cur_onehot_s;
    logic [2:0] tgt_onehot_s;
    logic       idle_open_s;
    logic       same_floor_call_s;
    logic [2:0] call_latch_s;
    logic       arrive_s;
    logic [2:0] pend_upd_s;
    logic [1:0] hold_code_s;
    logic [1:0] move_code_s;
    logic [2:0] pick_fwd_s;
    logic [2:0] pick_bwd_s;
    logic [1:0] sel_target_s;
    logic       sel_dir_up_s;

`ifndef DOOR_REOPEN_EN
    logic obstruct_unused_s;
    assign obstruct_unused_s = door_obstruct;
`endif

    // Decode current floor, call latching, arrival and next-target selection
    always_comb begin
        ea_valid_s = (ea != 2'b11);
        case (ea)
            2'd0:    cur_onehot_s = 3'b001;
            2'd1:    cur_onehot_s = 3'b010;
            2'd2:    cur_onehot_s = 3'b100;
            default: cur_onehot_s = 3'b000;
        endcase
        case (target_r)
            2'd0:    tgt_onehot_s = 3'b001;
            2'd1:    tgt_onehot_s = 3'b010;
            2'd2:    tgt_onehot_s = 3'b100;
            default: tgt_onehot_s = 3'b000;
        endcase
        idle_open_s       = (state_r == ST_IDLE) || (state_r == ST_OPEN);
        same_floor_call_s = idle_open_s && ((call & cur_onehot_s) != 3'b000);
        if (state_r == ST_FAULT) begin
            call_latch_s = 3'b000;
        end else if (idle_open_s) begin
            call_latch_s = call & ~cur_onehot_s;
        end else begin
            call_latch_s = call;
        end
        arrive_s    = (state_r == ST_MOVE) && (ea == target_r);
        pend_upd_s  = (pending_r | call_latch_s) & ~(arrive_s ? tgt_onehot_s : 3'b000);
        hold_code_s = call_code(ea, ea);
        move_code_s = call_code(target_r, ea);
        pick_fwd_s  = scan_pick(pending_r, ea, dir_up_r);
        pick_bwd_s  = scan_pick(pending_r, ea, ~dir_up_r);
        if (pick_fwd_s[2]) begin
            sel_target_s = pick_fwd_s[1:0];
            sel_dir_up_s = dir_up_r;
        end else if (pick_bwd_s[2]) begin
            sel_target_s = pick_bwd_s[1:0];
            sel_dir_up_s = ~dir_up_r;
        end else begin
            sel_target_s = ea;
            sel_dir_up_s = dir_up_r;
        end
    end

    // Dispatcher FSM with registered door/code/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            p_r          <= 1'b0;
            code_r       <= 2'b00;
            pending_r    <= 3'b000;
            dir_up_r     <= 1'b1;
            target_r     <= 2'b00;
            dwell_cnt_r  <= 8'd0;
            settle_cnt_r <= 8'd0;
            move_cnt_r   <= 8'd0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else if ((state_r != ST_FAULT) && !ea_valid_s) begin
            state_r   <= ST_FAULT;
            p_r       <= 1'b1;
            code_r    <= 2'b00;
            pending_r <= 3'b000;
            busy_r    <= 1'b0;
            fault_r   <= 1'b1;
        end else begin
            pending_r <= pend_upd_s;
            case (state_r)
                ST_IDLE: begin
                    code_r <= hold_code_s;
                    if (same_floor_call_s) begin
                        state_r     <= ST_OPEN;
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (pending_r != 3'b000) begin
                        state_r      <= ST_CLOSE;
                        target_r     <= sel_target_s;
                        dir_up_r     <= sel_dir_up_s;
                        settle_cnt_r <= 8'd0;
                        p_r          <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        p_r    <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    code_r <= hold_code_s;
                    if (same_floor_call_s) begin
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                        busy_r      <= 1'b0;
                    end
`ifdef DOOR_REOPEN_EN
                    else if (door_obstruct) begin
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                        busy_r      <= 1'b0;
                    end
`endif
                    else if (dwell_cnt_r == DWELL_LAST) begin
                        if (pending_r != 3'b000) begin
                            state_r      <= ST_CLOSE;
                            target_r     <= sel_target_s;
                            dir_up_r     <= sel_dir_up_s;
                            settle_cnt_r <= 8'd0;
                            p_r          <= 1'b1;
                            busy_r       <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            p_r     <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + 8'd1;
                        p_r         <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_CLOSE: begin
`ifdef DOOR_REOPEN_EN
                    if (door_obstruct) begin
                        state_r     <= ST_OPEN;
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                        code_r      <= hold_code_s;
                        busy_r      <= 1'b0;
                    end else
`endif
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r    <= ST_MOVE;
                        move_cnt_r <= 8'd0;
                        p_r        <= 1'b1;
                        code_r     <= move_code_s;
                        busy_r     <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                        p_r          <= 1'b1;
                        code_r       <= hold_code_s;
                        busy_r       <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (arrive_s) begin
                        state_r     <= ST_OPEN;
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                        code_r      <= hold_code_s;
                        busy_r      <= 1'b0;
                    end else if (move_cnt_r == MOVE_LAST) begin
                        state_r   <= ST_FAULT;
                        p_r       <= 1'b1;
                        code_r    <= 2'b00;
                        pending_r <= 3'b000;
                        busy_r    <= 1'b0;
                        fault_r   <= 1'b1;
                    end else begin
                        move_cnt_r <= move_cnt_r + 8'd1;
                        p_r        <= 1'b1;
                        code_r     <= move_code_s;
                        busy_r     <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    pending_r <= 3'b000;
                    fault_r   <= 1'b1;
                    busy_r    <= 1'b0;
                    code_r    <= 2'b00;
                    if (ea == 2'b00) begin
                        state_r     <= ST_OPEN;
                        dwell_cnt_r <= 8'd0;
                        p_r         <= 1'b0;
                    end else begin
                        p_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    p_r       <= 1'b0;
                    code_r    <= 2'b00;
                    pending_r <= 3'b000;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign p       = p_r;
    assign b0      = code_r[1];
    assign b1      = code_r[0];
    assign pending = pending_r;
    assign busy    = busy_r;
    assign fault   = fault_r;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Testbench for elevator_call_dispatcher: each step drives the inputs,
// queues the hand-derived expected {p,b0,b1,pending,busy,fault} for the
// coming edge, and compares it after that edge.
module tb_elevator_call_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] call;
    logic [1:0] ea;
    logic       door_obstruct;
    logic       p;
    logic       b0;
    logic       b1;
    logic [2:0] pending;
    logic       busy;
    logic       fault;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    elevator_call_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .call         (call),
        .ea           (ea),
        .door_obstruct(door_obstruct),
        .p            (p),
        .b0           (b0),
        .b1           (b1),
        .pending      (pending),
        .busy         (busy),
        .fault        (fault)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic ep, input logic [1:0] ecode,
                                      input logic [2:0] epend, input logic ebusy,
                                      input logic efault);
        return {ep, ecode, epend, ebusy, efault};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got p,code,pend,busy,fault=%b want %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] c, input logic [1:0] e,
                        input logic o, input logic [7:0] exp, input string tag);
        rst           = r;
        call          = c;
        ea            = e;
        door_obstruct = o;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), {p, b0, b1, pending, busy, fault}, exp_q.pop_front());
    endtask

    task automatic rep(input int n, input logic [2:0] c, input logic [1:0] e,
                       input logic o, input logic [7:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, c, e, o, exp, tag);
        end
    endtask

    task automatic do_reset(input logic [1:0] e);
        step(1'b1, 3'b000, e, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "reset");
        step(1'b1, 3'b000, e, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "reset2");
    endtask

    initial begin
        // Reset, then a single call F1 -> F3
        do_reset(2'b00);
        step(1'b0, 3'b100, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t1_latch");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b100, 1'b1, 1'b0), "t1_close");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b10, 3'b100, 1'b1, 1'b0), "t1_move");
        step(1'b0, 3'b000, 2'b10, 1'b0, mk(1'b0, 2'b11, 3'b000, 1'b0, 1'b0), "t1_arrive");
        rep(8, 3'b000, 2'b10, 1'b0, mk(1'b0, 2'b11, 3'b000, 1'b0, 1'b0), "t1_dwell");

        // SCAN order F1 -> F2 -> F3, call during arrival, then reverse to F1
        do_reset(2'b00);
        step(1'b0, 3'b110, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b110, 1'b0, 1'b0), "t2_latch");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b110, 1'b1, 1'b0), "t2_close1");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b01, 3'b110, 1'b1, 1'b0), "t2_move1");
        step(1'b0, 3'b011, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b101, 1'b0, 1'b0), "t2_arrive_call");
        rep(7, 3'b000, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b101, 1'b0, 1'b0), "t2_dwell1");
        rep(2, 3'b000, 2'b01, 1'b0, mk(1'b1, 2'b01, 3'b101, 1'b1, 1'b0), "t2_close2");
        step(1'b0, 3'b000, 2'b01, 1'b0, mk(1'b1, 2'b11, 3'b101, 1'b1, 1'b0), "t2_move2");
        step(1'b0, 3'b000, 2'b10, 1'b0, mk(1'b0, 2'b11, 3'b001, 1'b0, 1'b0), "t2_arrive2");
        rep(7, 3'b000, 2'b10, 1'b0, mk(1'b0, 2'b11, 3'b001, 1'b0, 1'b0), "t2_dwell2");
        rep(2, 3'b000, 2'b10, 1'b0, mk(1'b1, 2'b11, 3'b001, 1'b1, 1'b0), "t2_close3");
        step(1'b0, 3'b000, 2'b10, 1'b0, mk(1'b1, 2'b00, 3'b001, 1'b1, 1'b0), "t2_move3");
        step(1'b0, 3'b000, 2'b01, 1'b0, mk(1'b1, 2'b00, 3'b001, 1'b1, 1'b0), "t2_pass_f2");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "t2_arrive3");

        // Same-floor call at F2 restarts the dwell; a queued F1 call waits for it
        do_reset(2'b01);
        step(1'b0, 3'b010, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b000, 1'b0, 1'b0), "t3_same");
        rep(4, 3'b000, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b000, 1'b0, 1'b0), "t3_dwell");
        step(1'b0, 3'b011, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b001, 1'b0, 1'b0), "t3_restart");
        rep(7, 3'b000, 2'b01, 1'b0, mk(1'b0, 2'b01, 3'b001, 1'b0, 1'b0), "t3_dwell2");
        rep(2, 3'b000, 2'b01, 1'b0, mk(1'b1, 2'b01, 3'b001, 1'b1, 1'b0), "t3_close");
        step(1'b0, 3'b000, 2'b01, 1'b0, mk(1'b1, 2'b00, 3'b001, 1'b1, 1'b0), "t3_move_down");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "t3_arrive");

        // Move timeout -> sticky fault, recovery at F1
        do_reset(2'b00);
        step(1'b0, 3'b100, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t4_latch");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b100, 1'b1, 1'b0), "t4_close");
        rep(16, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b10, 3'b100, 1'b1, 1'b0), "t4_move");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b000, 1'b0, 1'b1), "t4_fault");
        step(1'b0, 3'b010, 2'b01, 1'b0, mk(1'b1, 2'b00, 3'b000, 1'b0, 1'b1), "t4_fault_hold");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b1), "t4_reopen");
        rep(10, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b1), "t4_sticky");

        // Invalid floor code -> fault; reset clears the sticky flag
        do_reset(2'b00);
        step(1'b0, 3'b000, 2'b11, 1'b0, mk(1'b1, 2'b00, 3'b000, 1'b0, 1'b1), "t5_ea_invalid");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b1), "t5_recover");

        // Reset in the middle of a move discards target and pending calls
        do_reset(2'b00);
        step(1'b0, 3'b010, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b010, 1'b0, 1'b0), "t6_latch");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b010, 1'b1, 1'b0), "t6_close");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b01, 3'b010, 1'b1, 1'b0), "t6_move");
        step(1'b1, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "t6_rst_move");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0), "t6_idle");

        // Door obstruction during the close settle
        do_reset(2'b00);
        step(1'b0, 3'b100, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t7_latch");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b100, 1'b1, 1'b0), "t7_close");
`ifdef DOOR_REOPEN_EN
        step(1'b0, 3'b000, 2'b00, 1'b1, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t7_reopen");
        rep(3, 3'b000, 2'b00, 1'b1, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t7_hold");
        rep(7, 3'b000, 2'b00, 1'b0, mk(1'b0, 2'b00, 3'b100, 1'b0, 1'b0), "t7_dwell");
        rep(2, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b00, 3'b100, 1'b1, 1'b0), "t7_close2");
        step(1'b0, 3'b000, 2'b00, 1'b0, mk(1'b1, 2'b10, 3'b100, 1'b1, 1'b0), "t7_move");
`else
        step(1'b0, 3'b000, 2'b00, 1'b1, mk(1'b1, 2'b00, 3'b100, 1'b1, 1'b0), "t7_close_ign");
        step(1'b0, 3'b000, 2'b00, 1'b1, mk(1'b1, 2'b10, 3'b100, 1'b1, 1'b0), "t7_move");
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
